uart_byte_tx: RTL

//  Serial UART transmitter; the line end of the cmd_parser byte interface (tx_data/new_tx_data/tx_busy).

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_byte_tx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte transmitter: FSM encoding,
// parity mode constants, baud counter width and the parity helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Wide enough for the largest legal CLK_PER_BIT (65535)
  localparam int unsigned BAUD_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Parity bit appended after the data bits for the given mode
  function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
    if (mode == PARITY_ODD) begin
      return ~^data;
    end else if (mode == PARITY_EVEN) begin
      return ^data;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLK_PER_BIT-1 and flags the last cycle of
// each bit. Held at zero while restart is high so the first bit after
// leaving idle gets a full period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 868
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart,
  output logic tick
);

  logic [BAUD_CNT_W-1:0] cnt;

  assign tick = (cnt == BAUD_CNT_W'(CLK_PER_BIT - 1));

  // Free-running bit counter, wraps on tick, parked at zero on restart
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: accepts one byte per handshake and shifts it out
// LSB first as start / 8 data / optional parity / 1-2 stop bits on tx.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 868,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       new_tx_data,
  output logic       tx_busy,
  output logic       tx,
  output logic       tx_overrun,
  input  logic       clr_overrun
);

  tx_state_t  state;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       stop_cnt;
  logic       par_r;
  logic       tick;
  logic       restart;

  assign restart = (state == ST_IDLE);

  uart_baud_tick #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rstn   (rstn),
    .restart(restart),
    .tick   (tick)
  );

  // Frame sequencer; tx and tx_busy are updated on the same edge as the
  // state change so each line level lasts exactly one baud period
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      par_r    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (new_tx_data) begin
            shreg   <= tx_data;
            par_r   <= parity_bit(tx_data, PARITY);
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              if (PARITY != PARITY_NONE) begin
                tx    <= par_r;
                state <= ST_PARITY;
              end else begin
                tx       <= 1'b1;
                stop_cnt <= 1'b0;
                state    <= ST_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              tx_busy <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky overrun flag: a request seen while busy sets it, set beats clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_overrun <= 1'b0;
    end else if (new_tx_data && tx_busy) begin
      tx_overrun <= 1'b1;
    end else if (clr_overrun) begin
      tx_overrun <= 1'b0;
    end
  end

endmodule
